// File: rtl/cache_dados.sv
// Direct-mapped, write-through / no-write-allocate data cache with one 32-bit word per line.
// A single transaction is in flight at a time; the CPU holds its request while stall is high.
module cache_dados #(
  parameter int unsigned INDEX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] address,
  input  logic [31:0] data,
  input  logic        r_en,
  input  logic        w_en,
  output logic [31:0] saida_cache,
  output logic        stall,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TAG_W  = ADDR_W - INDEX_W;
  localparam int unsigned LINES  = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_MEM_RD,
    S_MEM_WR,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_wr;

  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [DATA_W-1:0]   r_line [LINES];

  logic [DATA_W-1:0]   r_saida;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_rd;
  logic                r_mem_wr;
  logic [CNT_W-1:0]    r_hit_cnt;
  logic [CNT_W-1:0]    r_miss_cnt;

  logic                w_req;
  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;
  logic                w_latch;
  logic                w_hit_inc;
  logic                w_miss_inc;
  logic                w_line_upd;
  logic                w_fill;
  logic                w_out_upd;
  logic [DATA_W-1:0]   w_out_val;
  logic                w_mem_rd_nxt;
  logic                w_mem_wr_nxt;

  assign w_req   = r_en | w_en;
  assign w_index = r_addr[INDEX_W-1:0];
  assign w_tag   = r_addr[ADDR_W-1:INDEX_W];
  assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);

  // CPU-facing handshake is combinational so a hit releases the CPU two cycles after the request
  assign stall = (r_state == S_IDLE) ? w_req : (r_state != S_DONE);

  assign saida_cache = r_saida;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_rd      = r_mem_rd;
  assign mem_wr      = r_mem_wr;
  assign hit_cnt     = r_hit_cnt;
  assign miss_cnt    = r_miss_cnt;

  // Next-state and datapath control
  always_comb begin
    w_state_nxt  = r_state;
    w_latch      = 1'b0;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;
    w_line_upd   = 1'b0;
    w_fill       = 1'b0;
    w_out_upd    = 1'b0;
    w_out_val    = r_saida;
    w_mem_rd_nxt = r_mem_rd;
    w_mem_wr_nxt = r_mem_wr;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_latch     = 1'b1;
          w_state_nxt = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (r_is_wr) begin
          w_hit_inc    = w_hit;
          w_line_upd   = w_hit;
          w_miss_inc   = !w_hit;
          w_mem_wr_nxt = 1'b1;
          w_state_nxt  = S_MEM_WR;
        end else if (w_hit) begin
          w_hit_inc   = 1'b1;
          w_out_upd   = 1'b1;
          w_out_val   = r_line[w_index];
          w_state_nxt = S_DONE;
        end else begin
          w_miss_inc   = 1'b1;
          w_mem_rd_nxt = 1'b1;
          w_state_nxt  = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          w_fill       = 1'b1;
          w_out_upd    = 1'b1;
          w_out_val    = mem_rdata;
          w_mem_rd_nxt = 1'b0;
          w_state_nxt  = S_DONE;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          w_mem_wr_nxt = 1'b0;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_mem_rd_nxt = 1'b0;
        w_mem_wr_nxt = 1'b0;
      end
    endcase
  end

  // State, control registers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_wr     <= 1'b0;
      r_valid     <= '0;
      r_saida     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_rd <= w_mem_rd_nxt;
      r_mem_wr <= w_mem_wr_nxt;
      if (w_latch) begin
        r_addr      <= address;
        r_wdata     <= data;
        r_is_wr     <= w_en;
        r_mem_addr  <= address;
        r_mem_wdata <= data;
      end
      if (w_fill) begin
        r_valid[w_index] <= 1'b1;
      end
      if (w_out_upd) begin
        r_saida <= w_out_val;
      end
      if (w_hit_inc && (r_hit_cnt != {CNT_W{1'b1}})) begin
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
      if (w_miss_inc && (r_miss_cnt != {CNT_W{1'b1}})) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them
  always_ff @(posedge clk) begin
    if (w_line_upd) begin
      r_line[w_index] <= r_wdata;
    end
    if (w_fill) begin
      r_line[w_index] <= mem_rdata;
      r_tag[w_index]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_cache_dados.sv
// Directed bench for cache_dados with a fixed-latency main-memory model.
module tb_cache_dados;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] address;
  logic [31:0] data;
  logic        r_en;
  logic        w_en;
  logic [31:0] saida_cache;
  logic        stall;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_arr [4096];
  bit          loaded = 1'b0;
  logic        model_en;
  logic        model_ready;
  logic        man_ready;
  int          lat_cnt;
  bit          both_hi = 1'b0;

  int          stall_cyc;
  bit          saw_rd;
  bit          saw_wr;
  logic [11:0] seen_addr;
  logic [31:0] seen_wdata;

  cache_dados #(.INDEX_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .data        (data),
    .r_en        (r_en),
    .w_en        (w_en),
    .saida_cache (saida_cache),
    .stall       (stall),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  assign mem_ready = model_ready | man_ready;
  assign mem_rdata = mem_arr[mem_addr];

  // Memory model: mem_ready arrives in the third cycle a request is held
  always @(posedge clk) begin
    if (!loaded) begin
      mem_arr[12'h015] <= 32'hDEADBEEF;
      mem_arr[12'h025] <= 32'hCAFEF00D;
      mem_arr[12'h0F3] <= 32'h0BADF00D;
      loaded <= 1'b1;
    end
    if (mem_rd && mem_wr) both_hi <= 1'b1;
    model_ready <= 1'b0;
    if (rst) begin
      lat_cnt <= 0;
    end else if (model_en && (mem_rd || mem_wr) && !model_ready) begin
      if (lat_cnt == 1) begin
        model_ready <= 1'b1;
        lat_cnt     <= 0;
        if (mem_wr) mem_arr[mem_addr] <= mem_wdata;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one CPU request, scramble the bus while stalled, stop in the DONE cycle
  task automatic run_op(input logic wr, input logic [11:0] a, input logic [31:0] d);
    address = a; data = d; w_en = wr; r_en = !wr;
    stall_cyc = 0; saw_rd = 1'b0; saw_wr = 1'b0;
    seen_addr = '0; seen_wdata = '0;
    #1;
    while (stall && stall_cyc < 50) begin
      stall_cyc++;
      @(posedge clk); #1;
      address = 12'($urandom);
      data    = $urandom;
      if (mem_rd || mem_wr) begin
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
      end
      if (mem_rd) saw_rd = 1'b1;
      if (mem_wr) saw_wr = 1'b1;
    end
    chk("no_timeout", 32'(stall_cyc < 50), 32'd1);
  endtask

  task automatic finish_op();
    r_en = 1'b0; w_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; address = '0; data = '0; r_en = 1'b0; w_en = 1'b0;
    model_en = 1'b1; man_ready = 1'b0;
    do_reset();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_saida", saida_cache, 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_hit", 32'(hit_cnt), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);

    // Cold read miss
    run_op(1'b0, 12'h015, 32'h0);
    chk("cold_stall", stall_cyc, 32'd5);
    chk("cold_rd", 32'(saw_rd), 32'd1);
    chk("cold_addr", 32'(seen_addr), 32'h015);
    chk("cold_data", saida_cache, 32'hDEADBEEF);
    chk("cold_miss", 32'(miss_cnt), 32'd1);
    chk("cold_hit", 32'(hit_cnt), 32'd0);
    finish_op();
    chk("idle_stall", 32'(stall), 32'd0);

    // Read hit
    run_op(1'b0, 12'h015, 32'h0);
    chk("hit_stall", stall_cyc, 32'd2);
    chk("hit_no_rd", 32'(saw_rd), 32'd0);
    chk("hit_data", saida_cache, 32'hDEADBEEF);
    chk("hit_cnt1", 32'(hit_cnt), 32'd1);
    finish_op();

    // Conflict on index 5
    run_op(1'b0, 12'h025, 32'h0);
    chk("conf1_rd", 32'(saw_rd), 32'd1);
    chk("conf1_data", saida_cache, 32'hCAFEF00D);
    finish_op();
    run_op(1'b0, 12'h015, 32'h0);
    chk("conf2_rd", 32'(saw_rd), 32'd1);
    chk("conf2_data", saida_cache, 32'hDEADBEEF);
    chk("conf_miss", 32'(miss_cnt), 32'd3);
    finish_op();
    run_op(1'b0, 12'h015, 32'h0);
    chk("conf_tag1_hit", 32'(saw_rd), 32'd0);
    chk("conf_hit_cnt", 32'(hit_cnt), 32'd2);
    finish_op();

    // Write hit then read back
    run_op(1'b1, 12'h015, 32'h12345678);
    chk("wh_stall", stall_cyc, 32'd5);
    chk("wh_wr", 32'(saw_wr), 32'd1);
    chk("wh_rd", 32'(saw_rd), 32'd0);
    chk("wh_addr", 32'(seen_addr), 32'h015);
    chk("wh_wdata", seen_wdata, 32'h12345678);
    chk("wh_saida_kept", saida_cache, 32'hDEADBEEF);
    chk("wh_hit", 32'(hit_cnt), 32'd3);
    finish_op();
    run_op(1'b0, 12'h015, 32'h0);
    chk("wh_rb_rd", 32'(saw_rd), 32'd0);
    chk("wh_rb_data", saida_cache, 32'h12345678);
    chk("wh_rb_hit", 32'(hit_cnt), 32'd4);
    finish_op();

    // Write miss on an empty cache: no allocate
    do_reset();
    run_op(1'b1, 12'h0F3, 32'hA5A5A5A5);
    chk("wm_wr", 32'(saw_wr), 32'd1);
    chk("wm_wdata", seen_wdata, 32'hA5A5A5A5);
    chk("wm_miss", 32'(miss_cnt), 32'd1);
    chk("wm_hit", 32'(hit_cnt), 32'd0);
    chk("wm_saida", saida_cache, 32'd0);
    finish_op();
    run_op(1'b0, 12'h0F3, 32'h0);
    chk("wm_rb_rd", 32'(saw_rd), 32'd1);
    chk("wm_rb_data", saida_cache, 32'hA5A5A5A5);
    chk("wm_rb_miss", 32'(miss_cnt), 32'd2);
    finish_op();

    // Reset in the second MEM_RD cycle, then a late mem_ready
    address = 12'h015; r_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mr_rd_up", 32'(mem_rd), 32'd1);
    @(posedge clk); #1;
    model_en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_rd_drop", 32'(mem_rd), 32'd0);
    rst = 1'b0; r_en = 1'b0; man_ready = 1'b1;
    @(posedge clk); #1;
    man_ready = 1'b0;
    chk("mr_late_stall", 32'(stall), 32'd0);
    chk("mr_late_saida", saida_cache, 32'd0);
    chk("mr_hit0", 32'(hit_cnt), 32'd0);
    chk("mr_miss0", 32'(miss_cnt), 32'd0);
    @(posedge clk); #1;
    model_en = 1'b1;
    run_op(1'b0, 12'h015, 32'h0);
    chk("mr_reread_rd", 32'(saw_rd), 32'd1);
    chk("mr_reread_data", saida_cache, 32'h12345678);
    chk("mr_reread_miss", 32'(miss_cnt), 32'd1);
    finish_op();

    chk("rd_wr_exclusive", 32'(both_hi), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_dados.md
CACHE_DADOS -- requirements
Module: cache_dados

Interface
REQ-001 The block SHALL have parameter INDEX_W, default 4, giving the number of index bits; the cache has 2^INDEX_W lines.
REQ-002 The block SHALL derive the tag width as 12-INDEX_W: tag = address[11:INDEX_W], index = address[INDEX_W-1:0], one 32-bit word per line.
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 address  in  12  CPU word address.
REQ-006 data  in  32  CPU store data.
REQ-007 r_en  in  1  CPU load request; active-high; held until stall falls.
REQ-008 w_en  in  1  CPU store request; active-high; held until stall falls.
REQ-009 saida_cache  out  32  load result.
REQ-010 stall  out  1  CPU must hold its request and wait.
REQ-011 mem_addr  out  12  main-memory word address.
REQ-012 mem_wdata  out  32  main-memory write data.
REQ-013 mem_rd  out  1  main-memory read request.
REQ-014 mem_wr  out  1  main-memory write request.
REQ-015 mem_ready  in  1  main-memory completion strobe; one cycle.
REQ-016 mem_rdata  in  32  main-memory read data; valid with mem_ready.
REQ-017 hit_cnt  out  16  number of hits.
REQ-018 miss_cnt  out  16  number of misses.

Function
REQ-019 The block SHALL have the states IDLE, COMPARE, MEM_RD, MEM_WR and DONE.
REQ-020 stall SHALL be driven combinationally: 1 in IDLE when r_en or w_en is high, 1 in COMPARE, MEM_RD and MEM_WR, and 0 in DONE and in IDLE with no request.
REQ-021 In IDLE, when r_en or w_en is high, the block SHALL latch address, data and the operation, then go to COMPARE; if both are high, the operation is a write.
REQ-022 On a read hit in COMPARE (line valid and tag equal), saida_cache SHALL take the line data, hit_cnt SHALL increment, and the block SHALL go to DONE; read-hit latency is 2 cycles from request to stall low.
REQ-023 On a read miss in COMPARE, miss_cnt SHALL increment and the block SHALL go to MEM_RD.
REQ-024 In MEM_RD the block SHALL hold mem_rd=1 and mem_addr equal to the latched address until mem_ready.
REQ-025 On mem_ready in MEM_RD the block SHALL write mem_rdata into the line, set the line tag, set the line valid, drive saida_cache=mem_rdata, drop mem_rd and go to DONE.
REQ-026 On a write in COMPARE the cache SHALL be write-through and no-write-allocate: on a hit it updates the line data and increments hit_cnt; on a miss it increments miss_cnt and leaves the line untouched; both cases go to MEM_WR.
REQ-027 In MEM_WR the block SHALL hold mem_wr=1, mem_addr equal to the latched address and mem_wdata equal to the latched data until mem_ready, then drop mem_wr and go to DONE.
REQ-028 mem_rd and mem_wr SHALL never be high simultaneously, and both SHALL be registered outputs.
REQ-029 mem_ready SHALL be ignored in IDLE, COMPARE and DONE.
REQ-030 DONE SHALL last exactly one cycle and return to IDLE unconditionally; the CPU drops its request in the DONE cycle.
REQ-031 A request seen in IDLE on the cycle after DONE SHALL be treated as a new transaction.
REQ-032 saida_cache SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-033 hit_cnt and miss_cnt SHALL saturate at 16'hFFFF, with no wrap.
REQ-034 Address and data changes during stall SHALL NOT affect the transaction in progress, because they are latched.

Reset
REQ-035 rst SHALL force state IDLE and clear every valid bit.
REQ-036 rst SHALL set saida_cache, mem_addr, mem_wdata, mem_rd, mem_wr, hit_cnt and miss_cnt to 0.
REQ-037 Tag and data arrays need not be cleared by rst.
REQ-038 rst asserted mid-transaction (MEM_RD or MEM_WR) SHALL abandon it, drop mem_rd and mem_wr at the next edge, leave the target line invalid, and ignore any subsequent mem_ready.
REQ-039 stall SHALL be 0 on the cycle after reset when no request is present.

Verification (memory model latency 3 cycles unless stated)
REQ-040 Cold read: after reset, read address 12'h015 with memory word 32'hDEADBEEF -> mem_rd pulse with mem_addr=12'h015; saida_cache=32'hDEADBEEF; miss_cnt=1; stall high 5 cycles.
REQ-041 Read hit: repeat the read of 12'h015 -> no mem_rd; saida_cache=32'hDEADBEEF after 2 cycles; hit_cnt=1.
REQ-042 Conflict: read 12'h025 (same index 5, tag 2), then read 12'h015 -> both miss; miss_cnt=+2; line 5 holds tag 1 at the end.
REQ-043 Write hit then read: write 32'h12345678 to 12'h015 -> mem_wr with mem_wdata=32'h12345678; subsequent read of 12'h015 hits and returns 32'h12345678 with no mem_rd.
REQ-044 Write miss: write 32'hA5A5A5A5 to 12'h0F3 on an empty cache -> mem_wr issued; subsequent read of 12'h0F3 misses (no allocate).
REQ-045 Reset mid-refill: assert rst during MEM_RD cycle 2 -> mem_rd=0 next edge, late mem_ready ignored, re-read of the same address misses, all counters 0.
